// File: rtl/johnson_decoder.sv
// johnson_decoder: decodes a sampled Johnson-coded count bus into a binary
// index and a one-hot vector, flags illegal codes and out-of-sequence steps,
// tracks lock to the counting sequence and keeps a saturating error count.
// All outputs are registered, one clock after the sampling edge.
//
// Optional build macro JDEC_FLYWHEEL_EN: while LOCKED, a single bad sample
// is bridged by advancing to the predicted index; lock drops only after two
// consecutive bad samples.
module johnson_decoder #(
    parameter int WIDTH      = 4,
    parameter int LOCK_CNT   = 3,
    parameter int ALLOW_HOLD = 0,
    localparam int IW        = $clog2(2 * WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     jc_in,
    input  logic                 jc_valid,
    input  logic                 clr_err,
    output logic [IW-1:0]        index,
    output logic [2*WIDTH-1:0]   onehot,
    output logic                 index_valid,
    output logic                 code_err,
    output logic                 seq_err,
    output logic                 locked,
    output logic [7:0]           err_count
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        index_q, index_d;
    logic [2*WIDTH-1:0]   onehot_q, onehot_d;
    logic                 index_valid_q, index_valid_d;
    logic                 code_err_q, code_err_d;
    logic                 seq_err_q, seq_err_d;
    logic                 locked_q, locked_d;
    logic [3:0]           step_q, step_d;
    logic [7:0]           err_count_q, err_count_d;
`ifdef JDEC_FLYWHEEL_EN
    logic                 bad_q, bad_d;
`endif

    logic                 legal;
    logic                 correct;
    logic                 hold;
    logic [IW-1:0]        samp_idx;
    logic [IW-1:0]        pred_idx;

    // A legal code is a run of ones anchored at bit0 (includes all-zero)
    // or a run of ones anchored at the msb; x & (x+1) == 0 detects a low run.
    function automatic logic is_legal(input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] n;
        n = ~c;
        return ((c & (c + WIDTH'(1))) == '0) || ((n & (n + WIDTH'(1))) == '0);
    endfunction

    function automatic logic [IW:0] popcount(input logic [WIDTH-1:0] c);
        logic [IW:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + (IW + 1)'(c[i]);
        end
        return n;
    endfunction

    // msb clear: index is the number of ones; msb set: count down from 2*WIDTH
    // (all-ones naturally lands on WIDTH).
    function automatic logic [IW-1:0] decode(input logic [WIDTH-1:0] c);
        logic [IW:0] p;
        logic [IW:0] full;
        p    = popcount(c);
        full = (IW + 1)'(2 * WIDTH);
        if (c[WIDTH-1]) begin
            return IW'(full - p);
        end
        return IW'(p);
    endfunction

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (i == IW'(2 * WIDTH - 1)) begin
            return '0;
        end
        return i + IW'(1);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Sample classification; the registered index doubles as prev_index.
    always_comb begin
        legal    = is_legal(jc_in);
        samp_idx = decode(jc_in);
        pred_idx = next_idx(index_q);
        correct  = legal && (samp_idx == pred_idx);
        hold     = legal && (ALLOW_HOLD != 0) && (samp_idx == index_q);
    end

    // Next-state and output computation for the lock FSM.
    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        step_d        = step_q;
        index_valid_d = 1'b0;
        code_err_d    = 1'b0;
        seq_err_d     = 1'b0;
`ifdef JDEC_FLYWHEEL_EN
        bad_d         = bad_q;
`endif
        if (jc_valid) begin
            code_err_d = ~legal;
            case (state_q)
                UNLOCKED: begin
                    if (legal) begin
                        index_d       = samp_idx;
                        index_valid_d = 1'b1;
                        step_d        = 4'd0;
                        state_d       = LOCKING;
                    end
                end
                LOCKING: begin
                    if (!legal) begin
                        state_d = UNLOCKED;
                    end else if (hold) begin
                        index_valid_d = 1'b1;
                    end else if (correct) begin
                        index_d       = samp_idx;
                        index_valid_d = 1'b1;
                        step_d        = step_q + 4'd1;
                        if (step_q == 4'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        seq_err_d     = 1'b1;
                        index_d       = samp_idx;
                        index_valid_d = 1'b1;
                        step_d        = 4'd0;
                    end
                end
                LOCKED: begin
                    if (hold) begin
                        index_valid_d = 1'b1;
                    end else if (correct) begin
                        index_d       = samp_idx;
                        index_valid_d = 1'b1;
`ifdef JDEC_FLYWHEEL_EN
                        bad_d         = 1'b0;
`endif
                    end else begin
                        seq_err_d = legal;
`ifdef JDEC_FLYWHEEL_EN
                        if (bad_q) begin
                            // Second bad sample in a row: give up the flywheel.
                            state_d = UNLOCKED;
                            if (legal) begin
                                index_d       = samp_idx;
                                index_valid_d = 1'b1;
                            end
                        end else begin
                            bad_d         = 1'b1;
                            index_d       = pred_idx;
                            index_valid_d = 1'b1;
                        end
`else
                        state_d = UNLOCKED;
                        if (legal) begin
                            index_d       = samp_idx;
                            index_valid_d = 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                end
            endcase
        end
`ifdef JDEC_FLYWHEEL_EN
        if (state_d != LOCKED) begin
            bad_d = 1'b0;
        end
`endif
        onehot_d = (2 * WIDTH)'(1) << index_d;
        locked_d = (state_d == LOCKED);
        if (clr_err) begin
            err_count_d = 8'd0;
        end else if (code_err_d || seq_err_d) begin
            err_count_d = sat_inc(err_count_q);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // State and registered outputs, asynchronously reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= UNLOCKED;
            index_q       <= '0;
            onehot_q      <= (2 * WIDTH)'(1);
            index_valid_q <= 1'b0;
            code_err_q    <= 1'b0;
            seq_err_q     <= 1'b0;
            locked_q      <= 1'b0;
            step_q        <= 4'd0;
            err_count_q   <= 8'd0;
`ifdef JDEC_FLYWHEEL_EN
            bad_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            onehot_q      <= onehot_d;
            index_valid_q <= index_valid_d;
            code_err_q    <= code_err_d;
            seq_err_q     <= seq_err_d;
            locked_q      <= locked_d;
            step_q        <= step_d;
            err_count_q   <= err_count_d;
`ifdef JDEC_FLYWHEEL_EN
            bad_q         <= bad_d;
`endif
        end
    end

    assign index       = index_q;
    assign onehot      = onehot_q;
    assign index_valid = index_valid_q;
    assign code_err    = code_err_q;
    assign seq_err     = seq_err_q;
    assign locked      = locked_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Testbench for johnson_decoder (WIDTH=4, LOCK_CNT=3, ALLOW_HOLD=0).
// Directed samples push hand-computed expectations into a queue; a monitor
// pops and compares whenever the decoder presents a pulse output.
module tb_johnson_decoder;

    logic       clk;
    logic       reset;
    logic [3:0] jc_in;
    logic       jc_valid;
    logic       clr_err;
    logic [2:0] index;
    logic [7:0] onehot;
    logic       index_valid;
    logic       code_err;
    logic       seq_err;
    logic       locked;
    logic [7:0] err_count;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [2:0] idx;
        logic       iv;
        logic       ce;
        logic       se;
        logic       lk;
        logic [7:0] ec;
    } exp_t;

    exp_t q[$];

    johnson_decoder #(
        .WIDTH(4),
        .LOCK_CNT(3),
        .ALLOW_HOLD(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .jc_in(jc_in),
        .jc_valid(jc_valid),
        .clr_err(clr_err),
        .index(index),
        .onehot(onehot),
        .index_valid(index_valid),
        .code_err(code_err),
        .seq_err(seq_err),
        .locked(locked),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per presented output pulse.
    always @(negedge clk) begin
        if (!reset && (index_valid || code_err || seq_err)) begin
            checks++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: got idx=%0d iv=%0b ce=%0b se=%0b, required no output",
                         index, index_valid, code_err, seq_err);
            end else begin
                exp_t e;
                logic [7:0] oh;
                e  = q.pop_front();
                oh = 8'd1 << e.idx;
                if (index !== e.idx || onehot !== oh || index_valid !== e.iv ||
                    code_err !== e.ce || seq_err !== e.se || locked !== e.lk ||
                    err_count !== e.ec) begin
                    fails++;
                    $display("FAIL sample_out: got idx=%0d oh=%h iv=%0b ce=%0b se=%0b lk=%0b ec=%0d, required idx=%0d oh=%h iv=%0b ce=%0b se=%0b lk=%0b ec=%0d",
                             index, onehot, index_valid, code_err, seq_err, locked, err_count,
                             e.idx, oh, e.iv, e.ce, e.se, e.lk, e.ec);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Drive one sample (called at posedge+1) and queue its expected response.
    task automatic send(input logic [3:0] code, input logic clr, input int idx,
                        input bit iv, input bit ce, input bit se, input bit lk, input int ec);
        exp_t e;
        jc_in    = code;
        jc_valid = 1'b1;
        clr_err  = clr;
        e.idx = 3'(idx);
        e.iv  = iv;
        e.ce  = ce;
        e.se  = se;
        e.lk  = lk;
        e.ec  = 8'(ec);
        q.push_back(e);
        @(posedge clk);
        #1;
        jc_valid = 1'b0;
        clr_err  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_index"}, index, 0);
        check({tag, "_onehot"}, onehot, 1);
        check({tag, "_pulses"}, {index_valid, code_err, seq_err}, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_err_count"}, err_count, 0);
    endtask

    // Async reset pulse raised between clock edges and checked before the next edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        jc_in    = 4'b0000;
        jc_valid = 1'b0;
        clr_err  = 1'b0;
        #3;
        check_reset_vals("por");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Acquire and lock on the plain count
        send(4'b0000, 0, 0, 1, 0, 0, 0, 0);
        send(4'b0001, 0, 1, 1, 0, 0, 0, 0);
        send(4'b0011, 0, 2, 1, 0, 0, 0, 0);
        send(4'b0111, 0, 3, 1, 0, 0, 1, 0);
        send(4'b1111, 0, 4, 1, 0, 0, 1, 0);
        send(4'b1110, 0, 5, 1, 0, 0, 1, 0);
        send(4'b1100, 0, 6, 1, 0, 0, 1, 0);
        send(4'b1000, 0, 7, 1, 0, 0, 1, 0);
        send(4'b0000, 0, 0, 1, 0, 0, 1, 0);
        send(4'b0001, 0, 1, 1, 0, 0, 1, 0);
        send(4'b0011, 0, 2, 1, 0, 0, 1, 0);
        send(4'b0111, 0, 3, 1, 0, 0, 1, 0);

`ifdef JDEC_FLYWHEEL_EN
        // Flywheel: one bad sample is bridged, two in a row drop lock
        send(4'b1111, 0, 4, 1, 0, 0, 1, 0);
        send(4'b1010, 0, 5, 1, 1, 0, 1, 1);
        send(4'b1100, 0, 6, 1, 0, 0, 1, 1);
        send(4'b1010, 0, 7, 1, 1, 0, 1, 2);
        send(4'b1010, 0, 7, 0, 1, 0, 0, 3);
`else
        // Illegal code while LOCKED at 3, then relock
        send(4'b0101, 0, 3, 0, 1, 0, 0, 1);
        send(4'b1111, 0, 4, 1, 0, 0, 0, 1);
        send(4'b1110, 0, 5, 1, 0, 0, 0, 1);
        send(4'b1100, 0, 6, 1, 0, 0, 0, 1);
        send(4'b1000, 0, 7, 1, 0, 0, 1, 1);
        send(4'b0000, 0, 0, 1, 0, 0, 1, 1);
        send(4'b0001, 0, 1, 1, 0, 0, 1, 1);
        send(4'b0011, 0, 2, 1, 0, 0, 1, 1);
        // Wrong step while LOCKED at 2, then a repeat while LOCKING
        send(4'b1100, 0, 6, 1, 0, 1, 0, 2);
        send(4'b0011, 0, 2, 1, 0, 0, 0, 2);
        send(4'b0011, 0, 2, 1, 0, 1, 0, 3);
`endif

        // Fresh start, lock up to index 5, idle with outputs holding
        async_reset("rst_a");
        send(4'b0000, 0, 0, 1, 0, 0, 0, 0);
        send(4'b0001, 0, 1, 1, 0, 0, 0, 0);
        send(4'b0011, 0, 2, 1, 0, 0, 0, 0);
        send(4'b0111, 0, 3, 1, 0, 0, 1, 0);
        send(4'b1111, 0, 4, 1, 0, 0, 1, 0);
        send(4'b1110, 0, 5, 1, 0, 0, 1, 0);
        idle(3);
        check("hold_index", index, 5);
        check("hold_onehot", onehot, 8'h20);
        check("hold_locked", locked, 1);

        // Async reset while LOCKED at 5; next sample acquires without seq_err
        async_reset("rst_b");
        send(4'b1000, 0, 7, 1, 0, 0, 0, 0);
        send(4'b0000, 0, 0, 1, 0, 0, 0, 0);

        // Saturation of the error counter, then clear priority
        for (int i = 0; i < 300; i++) begin
            send(4'b1010, 0, 0, 0, 1, 0, 0, (i + 1 > 255) ? 255 : i + 1);
        end
        send(4'b1010, 1, 0, 0, 1, 0, 0, 0);
        send(4'b1010, 0, 0, 0, 1, 0, 0, 1);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        check("clr_idle", err_count, 0);

        idle(3);
        check("queue_drained", q.size(), 0);
        if (q.size() != 0) begin
            $display("FAIL missing_outputs: got %0d outstanding, required 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
